// File: rtl/kv_table_ctrl.sv
// Set-associative key/value table controller with tick-based entry expiry and
// oldest-entry replacement. One request in flight: GET 3 cycles, SET/DELETE 4.
module kv_table_ctrl #(
  parameter int KEY_SIZE = 96,
  parameter int VAL_SIZE = 32,
  parameter int IDX_BITS = 10,
  parameter int WAYS     = 4,
  parameter int TS_BITS  = 16,
  parameter int TICK_DIV = 1024,
  parameter int TTL      = 100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_op,
  input  logic [31:0]         in_hash,
  input  logic [KEY_SIZE-1:0] in_key,
  input  logic [VAL_SIZE-1:0] in_value,
  output logic                out_valid,
  output logic                out_hit,
  output logic                out_evict,
  output logic [VAL_SIZE-1:0] out_value,
  output logic [31:0]         evict_cnt
);

  localparam int SETS  = 1 << IDX_BITS;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] OP_GET = 2'b00;
  localparam logic [1:0] OP_SET = 2'b01;
  localparam logic [1:0] OP_DEL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    IDLE    = 3'd1,
    LOOKUP  = 3'd2,
    COMPARE = 3'd3,
    WRITE   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_BITS-1:0]  init_idx_q;
  logic [PS_W-1:0]      presc_q;
  logic [TS_BITS-1:0]   now_q;
  logic [TS_BITS-1:0]   now_lk_q;

  logic [1:0]           op_q;
  logic [IDX_BITS-1:0]  idx_q;
  logic [KEY_SIZE-1:0]  key_q;
  logic [VAL_SIZE-1:0]  val_q;

  logic [WAYS-1:0]      valid_mem [SETS];
  logic [KEY_SIZE-1:0]  key_mem   [SETS][WAYS];
  logic [VAL_SIZE-1:0]  val_mem   [SETS][WAYS];
  logic [TS_BITS-1:0]   ts_mem    [SETS][WAYS];

  logic [WAYS-1:0]      rd_valid_q;
  logic [KEY_SIZE-1:0]  rd_key_q [WAYS];
  logic [VAL_SIZE-1:0]  rd_val_q [WAYS];
  logic [TS_BITS-1:0]   rd_ts_q  [WAYS];

  logic [TS_BITS-1:0]   age_s [WAYS];
  logic [WAYS-1:0]      live_s;
  logic                 hit_s, free_s;
  logic [WAY_W-1:0]     hit_way_s, free_way_s, old_way_s, victim_s;
  logic [TS_BITS-1:0]   old_age_s;

  logic                 accept_s, is_set_s, is_del_s, evict_s, wr_en_s, rsp_hit_s;
  logic [VAL_SIZE-1:0]  rsp_val_s;

  logic                 wr_en_q, wr_valid_q;
  logic [WAY_W-1:0]     wr_way_q;
  logic                 out_valid_q, out_hit_q, out_evict_q;
  logic [VAL_SIZE-1:0]  out_value_q;
  logic [31:0]          evict_cnt_q;
  logic                 unused_hash_s;

  assign unused_hash_s = ^in_hash;
  assign accept_s      = in_valid && in_ready;

  // Reset dominates the response/handshake outputs so an aborted request never shows
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q && !rst;
  assign out_hit   = out_hit_q && !rst;
  assign out_evict = out_evict_q && !rst;
  assign out_value = rst ? {VAL_SIZE{1'b0}} : out_value_q;
  assign evict_cnt = evict_cnt_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT: begin
        if (init_idx_q == IDX_BITS'(SETS - 1)) state_d = IDLE;
        else                                   state_d = INIT;
      end
      IDLE: begin
        if (accept_s) state_d = LOOKUP;
        else          state_d = IDLE;
      end
      LOOKUP:  state_d = COMPARE;
      COMPARE: begin
        if ((op_q == OP_SET) || (op_q == OP_DEL)) state_d = WRITE;
        else                                      state_d = IDLE;
      end
      WRITE:   state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  // Init sweep pointer, timestamp prescaler and tick counter
  always_ff @(posedge clk) begin
    if (rst) begin
      init_idx_q <= '0;
      presc_q    <= '0;
      now_q      <= '0;
    end else begin
      init_idx_q <= (state_q == INIT) ? init_idx_q + IDX_BITS'(1) : '0;
      if (presc_q == PS_W'(TICK_DIV - 1)) begin
        presc_q <= '0;
        now_q   <= now_q + TS_BITS'(1);
      end else begin
        presc_q <= presc_q + PS_W'(1);
      end
    end
  end

  // Request capture on accept and set read during LOOKUP (now frozen with it)
  always_ff @(posedge clk) begin
    if (accept_s) begin
      op_q  <= in_op;
      idx_q <= in_hash[IDX_BITS-1:0];
      key_q <= in_key;
      val_q <= in_value;
    end
    if (state_q == LOOKUP) begin
      now_lk_q   <= now_q;
      rd_valid_q <= valid_mem[idx_q];
      for (int w = 0; w < WAYS; w++) begin
        rd_key_q[w] <= key_mem[idx_q][w];
        rd_val_q[w] <= val_mem[idx_q][w];
        rd_ts_q[w]  <= ts_mem[idx_q][w];
      end
    end
  end

  // Way scan: lowest live key match, lowest non-live way, oldest way (ties low)
  always_comb begin
    age_s      = '{default: '0};
    live_s     = '0;
    hit_s      = 1'b0;
    free_s     = 1'b0;
    hit_way_s  = '0;
    free_way_s = '0;
    old_way_s  = '0;
    old_age_s  = '0;
    for (int w = 0; w < WAYS; w++) begin
      age_s[w]   = now_lk_q - rd_ts_q[w];
      live_s[w]  = rd_valid_q[w] && (age_s[w] < TS_BITS'(TTL));
      hit_way_s  = (live_s[w] && (rd_key_q[w] == key_q) && !hit_s) ? WAY_W'(w) : hit_way_s;
      hit_s      = hit_s || (live_s[w] && (rd_key_q[w] == key_q));
      free_way_s = (!live_s[w] && !free_s) ? WAY_W'(w) : free_way_s;
      free_s     = free_s || !live_s[w];
      old_way_s  = (age_s[w] > old_age_s) ? WAY_W'(w) : old_way_s;
      old_age_s  = (age_s[w] > old_age_s) ? age_s[w] : old_age_s;
    end
  end

  assign is_set_s  = (op_q == OP_SET);
  assign is_del_s  = (op_q == OP_DEL);
  assign rsp_hit_s = hit_s && (op_q != OP_RSV);
  assign evict_s   = is_set_s && !hit_s && !free_s;
  assign wr_en_s   = is_set_s || (is_del_s && hit_s);
  assign victim_s  = hit_s ? hit_way_s : (free_s ? free_way_s : old_way_s);
  assign rsp_val_s = ((op_q == OP_GET) && hit_s) ? rd_val_q[hit_way_s] : {VAL_SIZE{1'b0}};

  // Response pulse, eviction counter and write command, all decided in COMPARE
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_hit_q   <= 1'b0;
      out_evict_q <= 1'b0;
      out_value_q <= '0;
      evict_cnt_q <= 32'd0;
      wr_en_q     <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_way_q    <= '0;
    end else if (state_q == COMPARE) begin
      out_valid_q <= 1'b1;
      out_hit_q   <= rsp_hit_s;
      out_evict_q <= evict_s;
      out_value_q <= rsp_val_s;
      wr_en_q     <= wr_en_s;
      wr_valid_q  <= is_set_s;
      wr_way_q    <= victim_s;
      if (evict_s && (evict_cnt_q != 32'hFFFF_FFFF)) begin
        evict_cnt_q <= evict_cnt_q + 32'd1;
      end
    end else begin
      out_valid_q <= 1'b0;
      out_hit_q   <= 1'b0;
      out_evict_q <= 1'b0;
      out_value_q <= '0;
      wr_en_q     <= 1'b0;
    end
  end

  // Valid bits: INIT clears one set per cycle, WRITE updates the chosen way
  always_ff @(posedge clk) begin
    if (!rst && (state_q == INIT)) begin
      valid_mem[init_idx_q] <= '0;
    end else if (!rst && (state_q == WRITE) && wr_en_q) begin
      valid_mem[idx_q][wr_way_q] <= wr_valid_q;
    end
  end

  // Entry payload storage, written only by SET
  always_ff @(posedge clk) begin
    if (!rst && (state_q == WRITE) && wr_en_q && wr_valid_q) begin
      key_mem[idx_q][wr_way_q] <= key_q;
      val_mem[idx_q][wr_way_q] <= val_q;
      ts_mem[idx_q][wr_way_q]  <= now_lk_q;
    end
  end

endmodule
